xls_fifo_ring: RTL
==================

# xls_fifo_ring

Parametrised multi-entry FIFO with XLS channel ready/valid semantics on both sides. It is the drop-in channel FIFO for zstd decoder procs that need more than one entry of buffering. It adds real depth, optional empty-bypass, and optional same-cycle push-when-full on pop. Storage is a circular buffer with wrapping read/write pointers; non-power-of-two depths are supported.

## Interface
- Width, 32, data bits per entry (>=1)
- Depth, 4, number of storage entries (>=1)
- EnableBypass, 0, 1: when empty, push data is presented combinationally on pop side
- RegisterPushOutputs, 1, 1: push_ready depends only on registered state; 0: push_ready also asserted when full and pop_ready=1
- clk  input  1  clock; all state updates on posedge clk
- rst  input  1  reset, synchronous, active-high
- push_ready  output  1  FIFO accepts push_data this cycle
- push_data  input  Width  data to enqueue
- push_valid  input  1  producer offers push_data
- pop_ready  input  1  consumer accepts pop_data
- pop_data  output  Width  head entry (or bypassed push_data)
- pop_valid  output  1  pop_data is valid

## Operation
- State: mem[Depth], rd_ptr and wr_ptr (PtrW = max(1, clog2(Depth)) bits), count (CntW = clog2(Depth+1) bits). full = (count == Depth); empty = (count == 0).
- push = push_valid & push_ready; pop = pop_valid & pop_ready.
- push_ready = !full, or (!full | pop_ready) when RegisterPushOutputs=0.
- pop_valid = !empty, or (!empty | push_valid) when EnableBypass=1.
- pop_data = mem[rd_ptr], or push_data when EnableBypass=1 and empty.
- Bypass transfer (EnableBypass=1, empty, push & pop): no write, pointers and count unchanged.
- Otherwise push writes mem[wr_ptr] and advances wr_ptr. Pop advances rd_ptr.
- Pointer wrap: value Depth-1 increments to 0, so Depth=3 gives 0,1,2,0.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds Depth and never underflows.
- Push when full is legal only with RegisterPushOutputs=0 and a simultaneous pop. The write lands in the slot freed by the pop, and count stays Depth.
- Reset:
  - count=0, rd_ptr=0, wr_ptr=0; mem is not reset.
  - While rst=1, push_ready=0 and pop_valid=0, and all transfers are ignored.
  - First cycle after reset: push_ready=1, pop_valid=0 (or push_valid if bypass is enabled).
  - Reset mid-operation discards all contents.

## Timing
- Non-bypass latency: data pushed at edge N is visible with pop_valid=1 in cycle N+1.
- Bypass latency: 0 cycles when empty.
- Throughput: one push and one pop per cycle sustained, including at full with RegisterPushOutputs=0, and at empty with bypass.
- Combinational paths: push_valid→pop_valid/pop_data only with EnableBypass=1. pop_ready→push_ready only with RegisterPushOutputs=0. No other input→output paths.
- pop_data and pop_valid hold steady while pop_valid=1 and pop_ready=0, unless bypassing.

## Structure
- Shared package xls_fifo_pkg:
  - ptr/count width functions
  - legality check constant: Depth>=1, Width>=1; an elaboration-time $fatal on violation
- Sub-module xls_fifo_ptr: wrapping counter with params Depth and PtrW, inputs clk/rst/inc, output ptr. Instantiated for rd_ptr and wr_ptr.
- mem is a plain register array; no memory macro.

## Test plan
- Depth=4, Bypass=0, RegPush=1: push 0xA1..0xA4 with pop_ready=0 → push_ready=0 after 4th push, count=4. Then pop 4 → data 0xA1..0xA4 in order, pop_valid=0 afterwards.
- Depth=3 wrap: 10 interleaved push/pop of incrementing values, holding occupancy at 1–2 → output sequence identical to input, pointers pass 2→0.
- Full + simultaneous, RegPush=0, Depth=2: fill with 0x1,0x2, then push 0x3 with pop_ready=1 → push_ready=1, 0x1 popped, contents 0x2,0x3.
- Bypass, Depth=2, empty: push_valid=1, push_data=0x55, pop_ready=1 → pop_valid=1 and pop_data=0x55 in the same cycle; count stays 0.
- Reset mid-operation: 3 entries stored, assert rst one cycle → push_ready=0 and pop_valid=0 during reset. Afterwards pop_valid=0, push_ready=1, and the next push/pop returns only new data.
- Randomized valid/ready stalls, Depth=5: scoreboard confirms no loss, duplication or reordering; count stays within 0..5.

Source files
------------

// File: rtl/xls_fifo_pkg.sv
// ============================================================================
// Module      : xls_fifo_pkg
// Description : Shared width helpers and parameter legality check for the
//               XLS channel FIFOs.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package xls_fifo_pkg;

    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_legal(input int depth, input int width);
        return (depth >= 1) && (width >= 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/xls_fifo_ptr.sv
// ============================================================================
// Module      : xls_fifo_ptr
// Description : Wrapping index counter, 0..Depth-1, for the FIFO ring.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module xls_fifo_ptr #(
    parameter int Depth = 4,
    parameter int PtrW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [PtrW-1:0] ptr
);

    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] ptr_d;

    // Explicit wrap so non-power-of-two depths never index past the array.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

`default_nettype wire

// File: rtl/xls_fifo_ring.sv
// ============================================================================
// Module      : xls_fifo_ring
// Description : Multi-entry circular-buffer FIFO with ready/valid channels,
//               optional empty bypass and optional push-when-full-on-pop.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module xls_fifo_ring
    import xls_fifo_pkg::*;
#(
    parameter int Width               = 32,
    parameter int Depth               = 4,
    parameter bit EnableBypass        = 1'b0,
    parameter bit RegisterPushOutputs = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             push_ready,
    input  logic [Width-1:0] push_data,
    input  logic             push_valid,
    input  logic             pop_ready,
    output logic [Width-1:0] pop_data,
    output logic             pop_valid
);

    localparam int c_PTR_W = ptr_w(Depth);
    localparam int c_CNT_W = cnt_w(Depth);
    localparam bit c_LEGAL = params_legal(Depth, Width);

    generate
        if (!c_LEGAL) begin : g_illegal
            $fatal(1, "xls_fifo_ring: Depth and Width must both be >= 1");
        end
    endgenerate

    logic [Width-1:0]   mem_q [Depth];
    logic [c_CNT_W-1:0] count_q;
    logic [c_CNT_W-1:0] count_d;
    logic [c_PTR_W-1:0] rd_ptr;
    logic [c_PTR_W-1:0] wr_ptr;

    logic w_full;
    logic w_empty;
    logic w_bypass_sel;
    logic w_push;
    logic w_pop;
    logic w_bypass_xfer;
    logic w_wr_en;
    logic w_rd_en;

    assign w_full  = (count_q == c_CNT_W'(Depth));
    assign w_empty = (count_q == '0);

    // Reset masks both handshakes so nothing transfers while rst is high.
    assign push_ready = !rst && (!w_full || (!RegisterPushOutputs && pop_ready));
    assign pop_valid  = !rst && (!w_empty || (EnableBypass && push_valid));

    assign w_bypass_sel = EnableBypass && w_empty;
    assign pop_data     = w_bypass_sel ? push_data : mem_q[rd_ptr];

    assign w_push        = push_valid && push_ready;
    assign w_pop         = pop_valid && pop_ready;
    assign w_bypass_xfer = w_bypass_sel && w_push && w_pop;
    assign w_wr_en       = w_push && !w_bypass_xfer;
    assign w_rd_en       = w_pop && !w_bypass_xfer;

    always_comb begin
        count_d = count_q;
        if (w_wr_en && !w_rd_en) begin
            count_d = count_q + 1'b1;
        end else if (w_rd_en && !w_wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // When full with a simultaneous pop, wr_ptr == rd_ptr: the old head is
    // read combinationally this cycle and overwritten at the edge.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr] <= push_data;
        end
    end

    xls_fifo_ptr #(
        .Depth (Depth),
        .PtrW  (c_PTR_W)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_rd_en),
        .ptr (rd_ptr)
    );

    xls_fifo_ptr #(
        .Depth (Depth),
        .PtrW  (c_PTR_W)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_wr_en),
        .ptr (wr_ptr)
    );

endmodule

`default_nettype wire
